// File: rtl/urisc_pkg.sv
// rtl/urisc_pkg.sv - shared uRISC widths and writeback packet type
package urisc_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = 3;

    // One pending register write: the MEM/WB latch contents.
    typedef struct packed {
        logic              valid;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] value;
    } wb_pkt_t;

    // True when a read of rd_idx must take the in-flight value instead of the
    // register file, giving write-before-read within a cycle.
    function automatic logic bypass_hit(input wb_pkt_t pkt, input logic [IDX_W-1:0] rd_idx);
        return pkt.valid && (pkt.idx == rd_idx);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB capture, decode read and forwarding signal bundle
//
// master : pipeline side (memory stage, decode stage, hazard unit)
// slave  : wb_stage
//   memwb  : dest_reg_value/index/write_valid, stall, flush (into wb_stage)
//   decode : rd_index_a/b in, rd_data_a/b out (combinational)
//   fwd    : fwd_valid/index/value out (latched write)
interface wb_stage_if;
    import urisc_pkg::*;

    logic [DATA_W-1:0] dest_reg_value_memwb_p1;
    logic [IDX_W-1:0]  dest_reg_index_memwb_p1;
    logic              dest_reg_write_valid_memwb_p1;
    logic              stall_memwb_p1;
    logic              flush_memwb_p1;

    logic [IDX_W-1:0]  rd_index_a_idwb_p1;
    logic [IDX_W-1:0]  rd_index_b_idwb_p1;
    logic [DATA_W-1:0] rd_data_a_wbid_p1;
    logic [DATA_W-1:0] rd_data_b_wbid_p1;

    logic              fwd_valid_wb_p2;
    logic [IDX_W-1:0]  fwd_index_wb_p2;
    logic [DATA_W-1:0] fwd_value_wb_p2;

    modport master (
        output dest_reg_value_memwb_p1, dest_reg_index_memwb_p1, dest_reg_write_valid_memwb_p1,
        output stall_memwb_p1, flush_memwb_p1,
        output rd_index_a_idwb_p1, rd_index_b_idwb_p1,
        input  rd_data_a_wbid_p1, rd_data_b_wbid_p1,
        input  fwd_valid_wb_p2, fwd_index_wb_p2, fwd_value_wb_p2
    );

    modport slave (
        input  dest_reg_value_memwb_p1, dest_reg_index_memwb_p1, dest_reg_write_valid_memwb_p1,
        input  stall_memwb_p1, flush_memwb_p1,
        input  rd_index_a_idwb_p1, rd_index_b_idwb_p1,
        output rd_data_a_wbid_p1, rd_data_b_wbid_p1,
        output fwd_valid_wb_p2, fwd_index_wb_p2, fwd_value_wb_p2
    );

endinterface

// File: rtl/rf_8x16.sv
// rtl/rf_8x16.sv - 8 x 16-bit register file, one sync write port, two comb read ports
//
// clk, rst_n            : clock, asynchronous active-low reset (clears all registers)
// we_i, widx_i, wdata_i : write port, applied on the rising edge
// ridx_a_i / rdata_a_o  : read port A (combinational)
// ridx_b_i / rdata_b_o  : read port B (combinational)
module rf_8x16
    import urisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_a_i,
    input  logic [IDX_W-1:0]  ridx_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    // Every register, R0 included, is ordinary storage.
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[ridx_a_i];
    assign rdata_b_o = mem_q[ridx_b_i];

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - uRISC writeback stage: MEM/WB latch, register file commit, bypassed reads
//
// clk  : single clock, rising edge
// rst  : asynchronous active-low reset (latch and register file cleared)
// bus  : wb_stage_if.slave - memwb capture inputs, decode read ports, forwarding outputs
module wb_stage
    import urisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);

    wb_pkt_t latch_q;
    wb_pkt_t latch_d;

    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    // Flush beats stall: a flushed slot becomes a clean all-zero bubble.
    always_comb begin
        latch_d = latch_q;
        if (bus.flush_memwb_p1) begin
            latch_d = '0;
        end else if (!bus.stall_memwb_p1) begin
            latch_d.valid = bus.dest_reg_write_valid_memwb_p1;
            latch_d.idx   = bus.dest_reg_index_memwb_p1;
            latch_d.value = bus.dest_reg_value_memwb_p1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    // The latched write commits on the edge that replaces it, so a flush only
    // removes the incoming instruction. A stalled latch rewrites the same
    // register each edge, which is harmless.
    rf_8x16 u_rf (
        .clk       (clk),
        .rst_n     (rst),
        .we_i      (latch_q.valid),
        .widx_i    (latch_q.idx),
        .wdata_i   (latch_q.value),
        .ridx_a_i  (bus.rd_index_a_idwb_p1),
        .ridx_b_i  (bus.rd_index_b_idwb_p1),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    assign bus.rd_data_a_wbid_p1 = bypass_hit(latch_q, bus.rd_index_a_idwb_p1) ? latch_q.value : rf_rdata_a;
    assign bus.rd_data_b_wbid_p1 = bypass_hit(latch_q, bus.rd_index_b_idwb_p1) ? latch_q.value : rf_rdata_b;

    assign bus.fwd_valid_wb_p2 = latch_q.valid;
    assign bus.fwd_index_wb_p2 = latch_q.idx;
    assign bus.fwd_value_wb_p2 = latch_q.value;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard testbench for wb_stage
module tb_wb_stage;
    import urisc_pkg::*;

    localparam int K_RD_A   = 0;
    localparam int K_RD_B   = 1;
    localparam int K_FWD_V  = 2;
    localparam int K_FWD_I  = 3;
    localparam int K_FWD_D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if bus();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc_n    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    chk_t mon_c;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_RD_A:  return bus.rd_data_a_wbid_p1;
            K_RD_B:  return bus.rd_data_b_wbid_p1;
            K_FWD_V: return {15'd0, bus.fwd_valid_wb_p2};
            K_FWD_I: return {13'd0, bus.fwd_index_wb_p2};
            default: return bus.fwd_value_wb_p2;
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
            mon_c = sb.pop_front();
            n_checks++;
            if (mon_c.cyc < cyc_n) begin
                n_fail++;
                $display("FAIL %s: not sampled in cycle %0d (now %0d), required %h", mon_c.name, mon_c.cyc, cyc_n, mon_c.exp);
            end else if (actual(mon_c.kind) !== mon_c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h (cycle %0d)", mon_c.name, actual(mon_c.kind), mon_c.exp, cyc_n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int idx, input logic [15:0] val, input logic stall, input logic flush);
        bus.dest_reg_write_valid_memwb_p1 = v;
        bus.dest_reg_index_memwb_p1       = idx[2:0];
        bus.dest_reg_value_memwb_p1       = val;
        bus.stall_memwb_p1                = stall;
        bus.flush_memwb_p1                = flush;
    endtask

    // Queue an expectation for the current cycle; read checks also steer the port index.
    task automatic expect_val(input int kind, input int idx, input logic [15:0] val, input string name);
        chk_t c;
        if (kind == K_RD_A) bus.rd_index_a_idwb_p1 = idx[2:0];
        if (kind == K_RD_B) bus.rd_index_b_idwb_p1 = idx[2:0];
        c.cyc  = cyc_n;
        c.kind = kind;
        c.exp  = val;
        c.name = name;
        sb.push_back(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        bus.rd_index_a_idwb_p1 = '0;
        bus.rd_index_b_idwb_p1 = '0;
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // Reset state: every register reads zero on both ports.
        for (int i = 0; i < 8; i++) begin
            expect_val(K_RD_A, i, 16'h0000, $sformatf("reset_rd_a_r%0d", i));
            expect_val(K_RD_B, 7 - i, 16'h0000, $sformatf("reset_rd_b_r%0d", 7 - i));
            expect_val(K_FWD_V, 0, 16'h0000, "reset_fwd_valid");
            step();
        end
        expect_val(K_FWD_I, 0, 16'h0000, "reset_fwd_index");
        expect_val(K_FWD_D, 0, 16'h0000, "reset_fwd_value");

        // Basic write R3=BEEF.
        drive(1'b1, 3, 16'hBEEF, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        expect_val(K_FWD_V, 0, 16'h0001, "basic_fwd_valid");
        expect_val(K_FWD_I, 0, 16'h0003, "basic_fwd_index");
        expect_val(K_FWD_D, 0, 16'hBEEF, "basic_fwd_value");
        expect_val(K_RD_A, 3, 16'hBEEF, "basic_bypass_r3");
        expect_val(K_RD_B, 4, 16'h0000, "basic_other_r4");
        step();
        expect_val(K_RD_A, 3, 16'hBEEF, "basic_committed_r3");
        expect_val(K_FWD_V, 0, 16'h0000, "basic_idle_fwd_valid");

        // Back-to-back writes to R5.
        drive(1'b1, 5, 16'h1111, 1'b0, 1'b0);
        step();
        drive(1'b1, 5, 16'h2222, 1'b0, 1'b0);
        expect_val(K_RD_A, 5, 16'h1111, "b2b_first_bypass_r5");
        step();
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        expect_val(K_RD_A, 5, 16'h2222, "b2b_second_bypass_a_r5");
        expect_val(K_RD_B, 5, 16'h2222, "b2b_second_bypass_b_r5");
        step();
        expect_val(K_RD_A, 5, 16'h2222, "b2b_committed_a_r5");
        expect_val(K_RD_B, 3, 16'hBEEF, "b2b_keep_r3");
        step();
        expect_val(K_RD_A, 5, 16'h2222, "b2b_later_r5");

        // Stall then flush on R2.
        drive(1'b1, 2, 16'h00AA, 1'b0, 1'b0);
        step();
        drive(1'b1, 2, 16'h0055, 1'b1, 1'b0);
        expect_val(K_RD_A, 2, 16'h00AA, "stall_latched_r2");
        for (int i = 0; i < 3; i++) begin
            step();
            expect_val(K_RD_A, 2, 16'h00AA, $sformatf("stall_hold_r2_%0d", i));
            expect_val(K_FWD_D, 0, 16'h00AA, $sformatf("stall_hold_fwd_value_%0d", i));
            expect_val(K_FWD_V, 0, 16'h0001, $sformatf("stall_hold_fwd_valid_%0d", i));
        end
        drive(1'b1, 2, 16'h0055, 1'b1, 1'b1);
        step();
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        expect_val(K_FWD_V, 0, 16'h0000, "flush_fwd_valid");
        expect_val(K_FWD_I, 0, 16'h0000, "flush_fwd_index");
        expect_val(K_FWD_D, 0, 16'h0000, "flush_fwd_value");
        expect_val(K_RD_A, 2, 16'h00AA, "flush_keep_r2");
        step();
        expect_val(K_RD_A, 2, 16'h00AA, "flush_later_r2");

        // Invalid write to R6.
        drive(1'b0, 6, 16'hFFFF, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        expect_val(K_FWD_V, 0, 16'h0000, "invalid_fwd_valid");
        expect_val(K_RD_A, 6, 16'h0000, "invalid_bypass_r6");
        step();
        expect_val(K_RD_A, 6, 16'h0000, "invalid_later_r6");

        // Asynchronous reset with R1=1234 still in the latch.
        drive(1'b1, 1, 16'h1234, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        expect_val(K_RD_A, 1, 16'h0000, "areset_now_r1");
        expect_val(K_FWD_V, 0, 16'h0000, "areset_now_fwd_valid");
        expect_val(K_RD_B, 3, 16'h0000, "areset_now_r3");
        step();
        rst = 1'b1;
        expect_val(K_RD_A, 1, 16'h0000, "areset_release_r1");
        expect_val(K_RD_B, 5, 16'h0000, "areset_release_r5");
        step();
        expect_val(K_RD_A, 1, 16'h0000, "areset_later_r1");
        expect_val(K_RD_B, 2, 16'h0000, "areset_later_r2");

        step();
        step();
        while (sb.size() > 0) begin
            mon_c = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never sampled, required %h", mon_c.name, mon_c.exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the uRISC five-stage pipeline, directly downstream of the memory stage. It captures the memory stage's destination-register triple into the MEM/WB pipeline latch and commits it to the 8 x 16-bit architectural register file on the following edge. It also serves the decode stage's two combinational read ports, with write-through bypass, and publishes the in-flight write to the hazard/forwarding unit.

## Interface
- `NUM_REGS`, 8, number of architectural registers.
- `DATA_W`, 16, register width.
- `IDX_W`, 3, register index width; must equal log2(`NUM_REGS`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- `dest_reg_value_memwb_p1` in 16: result from the memory stage.
- `dest_reg_index_memwb_p1` in 3: destination register index.
- `dest_reg_write_valid_memwb_p1` in 1: the instruction writes a register.
- `stall_memwb_p1` in 1: hold the latch.
- `flush_memwb_p1` in 1: capture a bubble.
- `rd_index_a_idwb_p1` in 3, `rd_index_b_idwb_p1` in 3: decode read indices.
- `rd_data_a_wbid_p1` out 16, `rd_data_b_wbid_p1` out 16: read data, combinational.
- `fwd_valid_wb_p2` out 1, `fwd_index_wb_p2` out 3, `fwd_value_wb_p2` out 16: latched write, for forwarding.

## Operation
- **Latch update (p1 to p2).** Priority at each edge:
  1. `flush` set: latch valid becomes 0; index and value become 0.
  2. Otherwise `stall` set: the latch holds.
  3. Otherwise the latch captures the value, the index, and `valid = dest_reg_write_valid`.
- **Flush vs. stall.** Flush wins when both are set.
- **Register file write.** Every edge where the latch is valid, `rf[latch_index] <= latch_value`.
  - During a stall the same write repeats; this is idempotent and allowed.
- **No hardwired zero.** All 8 registers are ordinary and writable, including R0.
- **Read with bypass.** `rd_data_x = (latch_valid && latch_index == rd_index_x) ? latch_value : rf[rd_index_x]`.
  - This gives write-before-read semantics within the same cycle.
  - Both ports may match simultaneously; both then return `latch_value`.
- **Forwarding outputs.** The `fwd_*` outputs are direct copies of the latch contents.
- **Arithmetic.** None. Values pass through bit-exact; there is no sign or width conversion.

## Timing
- **Reset values.** On reset: all 8 registers are 0; the latch is valid=0, index=0, value=0.
  - Consequently `fwd_valid=0`, `fwd_index=0`, `fwd_value=0`, and both `rd_data` outputs read 0.
- **Reset mid-operation.** A pending latched write is dropped and is not committed.
- **Capture to forward.** Inputs captured at edge N appear on `fwd_*` and on the bypass path after edge N.
- **Architectural commit.** The register file is updated at edge N+1. A read in cycle N+1 returns the new value, via bypass before the edge and via `rf` after it.
- **Read latency.** Zero cycles; the read path has no clocked element.
- **Back-to-back writes to the same index.** The younger write wins.
  - The register file is written at consecutive edges.
  - Bypass always shows the latch, which holds the youngest write.
- **Flush interaction.** A flush removes only the instruction being captured. A write already in the latch still commits at that edge.

## Structure
- **Shared package `urisc_pkg`:** `DATA_W`, `IDX_W`, `NUM_REGS` localparams, and typedef `wb_pkt_t` as a struct `{valid, idx, value}`.
- **Sub-module `rf_8x16`:**
  - Asynchronous active-low reset.
  - One synchronous write port (`we`, `widx`, `wdata`).
  - Two combinational read ports.
  - Owns only the storage; the bypass mux lives in `wb_stage`.

## Test plan
- **Reset:** hold `rst` low, then release → both read ports return 0x0000 for every index; `fwd_valid=0`.
- **Basic write:** present idx 3, value 0xBEEF, valid 1 → after edge 1, `fwd_*` = (1, 3, 0xBEEF) and port A reading R3 returns 0xBEEF via bypass; after edge 2 it still returns 0xBEEF with the inputs now idle.
- **Back-to-back:** write R5=0x1111, then R5=0x2222 on consecutive cycles → R5 reads 0x2222 from the cycle after the second capture onward; 0x1111 is never visible after that.
- **Stall then flush:**
  - Latch R2=0x00AA.
  - Stall for 3 cycles while the inputs carry R2=0x0055 → R2 stays 0x00AA throughout.
  - Assert stall and flush together → latch valid goes to 0; R2 remains 0x00AA.
- **Invalid write:** idx 6, value 0xFFFF, `valid=0` → R6 remains 0x0000 and `fwd_valid=0`.
- **Async reset mid-flight:** latch R1=0x1234, then drive `rst` low before the next edge → R1 reads 0x0000 immediately and stays 0x0000 after reset is released.
